// File: rtl/instr_encoder_if.sv
// Request/response bundle between an instruction producer and instr_encoder.
// The encoder sits on the slave side and the loader or sequencer sits on the master side.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [15:0]       instr_count;

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, instr_count
    );

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code, instr_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RISC-V fields into 32-bit instruction words and validates immediates.
// Each word is assigned a sequential byte address through a single registered output stage.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    instr_encoder_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       imm;
    logic [31:0]       word;
    logic [1:0]        err_next;
    logic              legal;
    logic              accept;
    logic              i_range_ok;
    logic              b_range_ok;
    logic              j_range_ok;

    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_valid_q;
    logic [1:0]        err_code_q;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] addr_base;
    logic [15:0]       count_base;
    logic [15:0]       count_inc;

    assign imm        = bus.imm;
    assign i_range_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_range_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_range_ok = (&imm[31:20]) | ~(|imm[31:20]);

    // Field packing and legality; error code 0 means the request is legal.
    always_comb begin
        word     = '0;
        err_next = 2'd0;
        case (bus.opcode)
            7'h03: begin
                word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                if (bus.funct3 != 3'b010) err_next = 2'd3;
                else if (!i_range_ok)     err_next = 2'd1;
            end
            7'h13: begin
                word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                if (!i_range_ok) err_next = 2'd1;
            end
            7'h23: begin
                word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
                if (!i_range_ok) err_next = 2'd1;
            end
            7'h33: begin
                word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            7'h17, 7'h37: begin
                word = {imm[31:12], bus.rd, bus.opcode};
                if (imm[11:0] != 12'd0) err_next = 2'd2;
            end
            7'h63: begin
                word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        imm[4:1], imm[11], bus.opcode};
                if (imm[0])           err_next = 2'd2;
                else if (!b_range_ok) err_next = 2'd1;
            end
            7'h6F: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
                if (imm[0])           err_next = 2'd2;
                else if (!j_range_ok) err_next = 2'd1;
            end
            default: err_next = 2'd3;
        endcase
    end

    assign legal      = (err_next == 2'd0);
    assign accept     = bus.in_valid && bus.in_ready;
    // Restart takes effect before a same-cycle accept so that word lands on BASE.
    assign addr_base  = restart ? BASE : counter;
    assign count_base = restart ? 16'd0 : count_q;
    assign count_inc  = (count_base == 16'hFFFF) ? count_base : count_base + 16'd1;

    // Output register, address counter and emitted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
            count_q     <= 16'd0;
            counter     <= BASE;
        end else begin
            err_valid_q <= accept && !legal;
            if (accept && !legal) err_code_q <= err_next;
            if (accept && legal) begin
                out_valid_q <= 1'b1;
                out_instr_q <= word;
                out_addr_q  <= addr_base;
                counter     <= addr_base + ADDR_W'(4);
                count_q     <= count_inc;
            end else begin
                if (bus.out_ready) out_valid_q <= 1'b0;
                counter <= addr_base;
                count_q <= count_base;
            end
        end
    end

    assign bus.in_ready    = !out_valid_q || bus.out_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.err_valid   = err_valid_q;
    assign bus.err_code    = err_code_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-bit address so wrap-around is reachable.
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    instr_encoder_if #(.ADDR_W(4)) bus();

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                           input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] imm_v);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.rd       = rd_v;
        bus.rs1      = rs1_v;
        bus.rs2      = rs2_v;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = imm_v;
    endtask

    task automatic set_idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_restart();
        set_idle();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_out_instr: got=%h exp=0", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL rst_out_addr: got=%h exp=0", bus.out_addr); end
        total++; if (bus.err_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_err_valid: got=%b exp=0", bus.err_valid); end
        total++; if (bus.err_code !== 2'd0) begin bad++; $display("[TB] FAIL rst_err_code: got=%0d exp=0", bus.err_code); end
        total++; if (bus.instr_count !== 16'd0) begin bad++; $display("[TB] FAIL rst_count: got=%0d exp=0", bus.instr_count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_itype();
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid: got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_instr !== 32'hFFF00093) begin bad++; $display("[TB] FAIL addi_instr: got=%h exp=FFF00093", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL addi_addr: got=%h exp=0", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd1) begin bad++; $display("[TB] FAIL addi_count: got=%0d exp=1", bus.instr_count); end
        set_idle();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_drain: got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_branch_jump();
        do_restart();
        total++; if (bus.instr_count !== 16'd0) begin bad++; $display("[TB] FAIL restart_count: got=%0d exp=0", bus.instr_count); end
        set_req(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8);
        tick();
        total++; if (bus.out_instr !== 32'hFE000CE3) begin bad++; $display("[TB] FAIL beq_instr: got=%h exp=FE000CE3", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL beq_addr: got=%h exp=0", bus.out_addr); end
        set_req(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        tick();
        total++; if (bus.out_instr !== 32'h001000EF) begin bad++; $display("[TB] FAIL jal_instr: got=%h exp=001000EF", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h4) begin bad++; $display("[TB] FAIL jal_addr: got=%h exp=4", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd2) begin bad++; $display("[TB] FAIL jal_count: got=%0d exp=2", bus.instr_count); end
        set_idle();
        tick();
    endtask

    task automatic test_utype();
        do_restart();
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick();
        total++; if (bus.out_instr !== 32'h123452B7) begin bad++; $display("[TB] FAIL lui_instr: got=%h exp=123452B7", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL lui_addr: got=%h exp=0", bus.out_addr); end
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        tick();
        total++; if (bus.err_valid !== 1'b1) begin bad++; $display("[TB] FAIL lui_bad_err: got=%b exp=1", bus.err_valid); end
        total++; if (bus.err_code !== 2'd2) begin bad++; $display("[TB] FAIL lui_bad_code: got=%0d exp=2", bus.err_code); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lui_bad_valid: got=%b exp=0", bus.out_valid); end
        total++; if (bus.instr_count !== 16'd1) begin bad++; $display("[TB] FAIL lui_bad_count: got=%0d exp=1", bus.instr_count); end
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        total++; if (bus.err_valid !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse_len: got=%b exp=0", bus.err_valid); end
        total++; if (bus.out_addr !== 4'h4) begin bad++; $display("[TB] FAIL after_err_addr: got=%h exp=4", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd2) begin bad++; $display("[TB] FAIL after_err_count: got=%0d exp=2", bus.instr_count); end
        set_idle();
        tick();
    endtask

    task automatic test_formats();
        vec_t v[8];
        v[0] = '{7'h03, 5'd2, 5'd3, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFFC1A103};
        v[1] = '{7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h0000_07F8, 32'h7E512C23};
        v[2] = '{7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h403100B3};
        v[3] = '{7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h80000013};
        v[4] = '{7'h17, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFFF017};
        v[5] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd1, 7'h00, 32'h0000_0FFE, 32'h7E001FE3};
        v[6] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFE, 32'hFFFFF06F};
        v[7] = '{7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF00013};
        do_restart();
        for (int i = 0; i < 8; i++) begin
            set_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL fmt%0d_valid: got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.out_instr !== v[i].exp) begin bad++; $display("[TB] FAIL fmt%0d_instr: got=%h exp=%h", i, bus.out_instr, v[i].exp); end
            total++; if (bus.out_addr !== 4'((i % 4) * 4)) begin bad++; $display("[TB] FAIL fmt%0d_addr: got=%h exp=%h", i, bus.out_addr, 4'((i % 4) * 4)); end
            total++; if (bus.err_valid !== 1'b0) begin bad++; $display("[TB] FAIL fmt%0d_err: got=%b exp=0", i, bus.err_valid); end
        end
        set_idle();
        tick();
        total++; if (bus.instr_count !== 16'd8) begin bad++; $display("[TB] FAIL fmt_count: got=%0d exp=8", bus.instr_count); end
    endtask

    task automatic test_errors();
        vec_t v[10];
        v[0] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'd1};
        v[1] = '{7'h03, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'd3};
        v[2] = '{7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'd3};
        v[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'd2};
        v[4] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'd2};
        v[5] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'd1};
        v[6] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'd1};
        v[7] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'd2};
        v[8] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_F7FF, 32'd1};
        v[9] = '{7'h03, 5'd1, 5'd0, 5'd0, 3'd2, 7'h00, 32'h0000_0800, 32'd1};
        do_restart();
        for (int i = 0; i < 10; i++) begin
            set_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
            tick();
            total++; if (bus.err_valid !== 1'b1) begin bad++; $display("[TB] FAIL err%0d_valid: got=%b exp=1", i, bus.err_valid); end
            total++; if (bus.err_code !== v[i].exp[1:0]) begin bad++; $display("[TB] FAIL err%0d_code: got=%0d exp=%0d", i, bus.err_code, v[i].exp[1:0]); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL err%0d_out_valid: got=%b exp=0", i, bus.out_valid); end
            total++; if (bus.instr_count !== 16'd0) begin bad++; $display("[TB] FAIL err%0d_count: got=%0d exp=0", i, bus.instr_count); end
        end
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL err_then_addr: got=%h exp=0", bus.out_addr); end
        total++; if (bus.err_valid !== 1'b0) begin bad++; $display("[TB] FAIL err_then_valid: got=%b exp=0", bus.err_valid); end
        set_idle();
        tick();
    endtask

    task automatic test_backpressure();
        do_restart();
        bus.out_ready = 1'b0;
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_first_valid: got=%b exp=1", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got=%b exp=0", bus.in_ready); end
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.out_instr !== 32'hFFF00093) begin bad++; $display("[TB] FAIL bp_hold%0d_instr: got=%h exp=FFF00093", i, bus.out_instr); end
            total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL bp_hold%0d_addr: got=%h exp=0", i, bus.out_addr); end
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold%0d_valid: got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold%0d_ready: got=%b exp=0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_second_valid: got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_instr !== 32'h123452B7) begin bad++; $display("[TB] FAIL bp_second_instr: got=%h exp=123452B7", bus.out_instr); end
        total++; if (bus.out_addr !== 4'h4) begin bad++; $display("[TB] FAIL bp_second_addr: got=%h exp=4", bus.out_addr); end
        set_idle();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got=%b exp=0", bus.out_valid); end
        total++; if (bus.instr_count !== 16'd2) begin bad++; $display("[TB] FAIL bp_count: got=%0d exp=2", bus.instr_count); end
    endtask

    task automatic test_back_to_back();
        do_restart();
        for (int i = 0; i < 3; i++) begin
            set_req(7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_valid: got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.out_addr !== 4'(i * 4)) begin bad++; $display("[TB] FAIL b2b%0d_addr: got=%h exp=%h", i, bus.out_addr, 4'(i * 4)); end
        end
        // Restart coinciding with an accept: this word must take the base address.
        set_req(7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL rs_accept_addr: got=%h exp=0", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd1) begin bad++; $display("[TB] FAIL rs_accept_count: got=%0d exp=1", bus.instr_count); end
        total++; if (bus.out_instr !== 32'h00000493) begin bad++; $display("[TB] FAIL rs_accept_instr: got=%h exp=00000493", bus.out_instr); end
        set_req(7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        total++; if (bus.out_addr !== 4'h4) begin bad++; $display("[TB] FAIL rs_next_addr: got=%h exp=4", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd2) begin bad++; $display("[TB] FAIL rs_next_count: got=%0d exp=2", bus.instr_count); end
        bus.out_ready = 1'b0;
        set_idle();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rs_held_valid: got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_addr !== 4'h4) begin bad++; $display("[TB] FAIL rs_held_addr: got=%h exp=4", bus.out_addr); end
        total++; if (bus.out_instr !== 32'h00000513) begin bad++; $display("[TB] FAIL rs_held_instr: got=%h exp=00000513", bus.out_instr); end
        total++; if (bus.instr_count !== 16'd0) begin bad++; $display("[TB] FAIL rs_held_count: got=%0d exp=0", bus.instr_count); end
        bus.out_ready = 1'b1;
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        tick();
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL rs_after_addr: got=%h exp=0", bus.out_addr); end
        set_idle();
        tick();
    endtask

    task automatic test_wrap();
        do_restart();
        for (int i = 0; i < 5; i++) begin
            set_req(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
            tick();
            total++; if (bus.out_addr !== 4'((i * 4) % 16)) begin bad++; $display("[TB] FAIL wrap%0d_addr: got=%h exp=%h", i, bus.out_addr, 4'((i * 4) % 16)); end
        end
        total++; if (bus.instr_count !== 16'd5) begin bad++; $display("[TB] FAIL wrap_count: got=%0d exp=5", bus.instr_count); end
        total++; if (bus.err_valid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err: got=%b exp=0", bus.err_valid); end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        set_req(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rm_held_valid: got=%b exp=1", bus.out_valid); end
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rm_valid: got=%b exp=0", bus.out_valid); end
        total++; if (bus.out_instr !== 32'h0) begin bad++; $display("[TB] FAIL rm_instr: got=%h exp=0", bus.out_instr); end
        total++; if (bus.instr_count !== 16'd0) begin bad++; $display("[TB] FAIL rm_count: got=%0d exp=0", bus.instr_count); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        total++; if (bus.out_addr !== 4'h0) begin bad++; $display("[TB] FAIL rm_after_addr: got=%h exp=0", bus.out_addr); end
        total++; if (bus.instr_count !== 16'd1) begin bad++; $display("[TB] FAIL rm_after_count: got=%0d exp=1", bus.instr_count); end
        set_idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.opcode    = 7'd0;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.funct3    = 3'd0;
        bus.funct7    = 7'd0;
        bus.imm       = 32'd0;
        bus.out_ready = 1'b1;
        test_reset();
        test_itype();
        test_branch_jump();
        test_utype();
        test_formats();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V instruction encoder: packs decoded fields (opcode, registers, funct, 32-bit immediate) back into a 32-bit instruction word.
- It is the inverse of the core's immediate generator. Used by the program loader and self-test sequencer to write instruction memory.
- Validates each immediate against its format's range and alignment, and assigns each emitted word a sequential byte address.
- One registered output stage with valid/ready backpressure.

Parameters:
- ADDR_W, 10, width of the instruction memory byte address. The counter wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address assigned to the first word after reset or restart. Must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous; reloads the address counter to BASE_ADDR
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type only)
- imm  in  32  full-width immediate value (byte offset for B/J)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address for out_instr
- err_valid  out  1  one-cycle pulse: the accepted request was rejected
- err_code  out  2  1 = immediate out of range; 2 = misaligned; 3 = unsupported opcode/funct3
- instr_count  out  16  words emitted since reset or restart; saturates at 0xFFFF

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_addr=0, err_valid=0, err_code=0, instr_count=0.
  - Address counter = BASE_ADDR.
  - Any pending word is dropped.
- Ready: in_ready = !out_valid || out_ready (combinational). No other path from in_valid to in_ready.
- Latency: an accepted legal request appears on out_instr/out_addr with out_valid=1 on the next edge.
- Holding: while out_valid && !out_ready, out_instr and out_addr are held stable.
- Pass-through: output handshake and input handshake in the same cycle gives back-to-back words with no bubble.
- Legal accept:
  - out_addr <= counter; counter <= counter + 4 (wraps); instr_count increments.
- Illegal accept:
  - Request is consumed. out_valid <= 0 if the old word was taken, otherwise it holds the old word.
  - err_valid=1 for exactly one cycle with err_code set.
  - Counter and instr_count do not change.
- Encodings and checks. Range checks are two's complement on imm[31:0]:
  - 0x03 (load):
    - Requires funct3 = 010, else code 3.
    - imm[31:11] must all be equal, else code 1.
    - Word = {imm[11:0], rs1, funct3, rd, opcode}.
  - 0x13 (I-type): same I format and range rule; any funct3 is allowed.
  - 0x23 (store):
    - Range rule as for I-type.
    - Word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 0x33 (R-type):
    - imm is ignored.
    - Word = {funct7, rs2, rs1, funct3, rd, opcode}.
  - 0x17 / 0x37 (U-type):
    - imm[11:0] must be 0, else code 2.
    - Word = {imm[31:12], rd, opcode}.
  - 0x63 (branch):
    - Check order: imm[0]=0, else code 2; then imm[31:12] all equal, else code 1.
    - Word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - 0x6F (jump):
    - Check order: imm[0]=0, else code 2; then imm[31:20] all equal, else code 1.
    - Word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Any other opcode: code 3.
- Restart:
  - Sets counter = BASE_ADDR and instr_count = 0. It does not disturb a pending output word.
  - If an accept happens in the same cycle, that word gets BASE_ADDR, and afterwards counter = BASE_ADDR+4 and instr_count = 1.
- Address wrap: counter at 2^ADDR_W - 4 wraps to 0 with no error.
- Reset mid-transfer: everything is cleared immediately; the held word is lost.

Test Plan:
- addi: opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF → out_instr=0xFFF00093, out_addr=0, next cycle.
- beq: opcode=0x63, rs1=rs2=0, imm=0xFFFFFFF8 → 0xFE000CE3. jal: opcode=0x6F, rd=1, imm=0x800 → 0x001000EF, out_addr=4.
- lui: opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7. Same with imm=0x12345001 → err_valid pulse, err_code=2, no out_valid, address unchanged.
- addi with imm=2048 → err_code=1. Load with funct3=000 → err_code=3. Opcode 0x7F → err_code=3. instr_count unchanged in all three cases.
- Backpressure: hold out_ready=0 for 3 cycles with a second request pending → in_ready=0 and the word stays stable. Raise out_ready → second word follows on the next edge with no gap; addresses 0 then 4.
- Restart asserted together with an accept after 3 words → that word gets out_addr=BASE_ADDR and instr_count=1. With ADDR_W=4, the 5th word after restart has out_addr=0 (wrap). Asserting rst_n=0 while a word is held → out_valid drops immediately.
